// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD card CMD-line sequencer: clocked 48-bit command out, optional R48 response in.
module sd_cmd_engine #(
    parameter int CLKDIV  = 125,
    parameter int TIMEOUT = 64
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [1:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_busy,
    output logic        SD_CLK,
    inout  wire         SD_CMD
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECV, FINISH} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] div_cnt;
    logic        tick, rise, fall;

    logic [31:0] arg;
    logic [7:0]  ctrl;
    logic        done, tmo, crc_err, end_err;
    logic [31:0] resp;
    logic [5:0]  resp_idx;

    logic [39:0] tx_sreg;
    logic [5:0]  tx_cnt;
    logic [6:0]  tx_crc;
    logic        cmd_oe, cmd_bit;

    logic [46:0] rx_sreg;
    logic [5:0]  rx_cnt;
    logic [6:0]  rx_crc;
    logic [15:0] wait_cnt;
    logic [3:0]  fin_cnt;

    logic        cmd_in, wr_en, wr_ctrl, rd_en;
    logic [31:0] rd_mux;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    assign cmd_in  = SD_CMD;
    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign rise    = tick && !SD_CLK;
    assign fall    = tick && SD_CLK;
    assign o_busy  = (state != IDLE);
    assign wr_en   = i_request && i_rw && (state == IDLE);
    assign wr_ctrl = wr_en && (i_address == 2'd1);
    assign rd_en   = i_request && !i_rw;

    // Header bits, then the running CRC7, then the end bit.
    assign cmd_bit = (tx_cnt < 6'd40) ? tx_sreg[39] :
                     (tx_cnt < 6'd47) ? tx_crc[6]   : 1'b1;
    assign SD_CMD  = cmd_oe ? cmd_bit : 1'bz;

    always_comb begin
        rd_mux = 32'd0;
        case (i_address)
            2'd0: rd_mux = arg;
            2'd1: rd_mux = {24'd0, ctrl};
            2'd2: rd_mux = {18'd0, resp_idx, 3'd0, end_err, crc_err, tmo, done, o_busy};
            2'd3: rd_mux = resp;
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt <= 16'd0;
            SD_CLK  <= 1'b0;
        end else if (state == IDLE) begin
            div_cnt <= 16'd0;
            SD_CLK  <= 1'b0;
        end else if (tick) begin
            div_cnt <= 16'd0;
            SD_CLK  <= !SD_CLK;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (wr_ctrl) state_next = SEND;
            SEND:       if (fall && tx_cnt == 6'd47)
                            state_next = ctrl[6] ? WAIT_START : FINISH;
            WAIT_START: if (rise) begin
                            if (!cmd_in)                  state_next = RECV;
                            else if (wait_cnt == TMO_LAST) state_next = FINISH;
                        end
            RECV:       if (rise && rx_cnt == 6'd47) state_next = FINISH;
            FINISH:     if (fall && fin_cnt == 4'd8) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_ready  <= 1'b0;
            o_rdata  <= 32'd0;
            arg      <= 32'd0;
            ctrl     <= 8'd0;
            done     <= 1'b0;
            tmo      <= 1'b0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            resp     <= 32'd0;
            resp_idx <= 6'd0;
            tx_sreg  <= 40'd0;
            tx_cnt   <= 6'd0;
            tx_crc   <= 7'd0;
            cmd_oe   <= 1'b0;
            rx_sreg  <= 47'd0;
            rx_cnt   <= 6'd0;
            rx_crc   <= 7'd0;
            wait_cnt <= 16'd0;
            fin_cnt  <= 4'd0;
        end else begin
            o_ready <= i_request;
            if (rd_en) o_rdata <= rd_mux;

            if (wr_en && i_address == 2'd0) arg <= i_wdata;
            if (wr_ctrl) begin
                ctrl     <= i_wdata[7:0];
                done     <= 1'b0;
                tmo      <= 1'b0;
                crc_err  <= 1'b0;
                end_err  <= 1'b0;
                tx_sreg  <= {2'b01, i_wdata[5:0], arg};
                tx_cnt   <= 6'd0;
                tx_crc   <= 7'd0;
                cmd_oe   <= 1'b1;
                rx_cnt   <= 6'd0;
                wait_cnt <= 16'd0;
                fin_cnt  <= 4'd0;
            end

            case (state)
                SEND: if (fall) begin
                    if (tx_cnt == 6'd47) begin
                        cmd_oe <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 6'd1;
                        if (tx_cnt < 6'd40) begin
                            tx_crc  <= crc7_next(tx_crc, tx_sreg[39]);
                            tx_sreg <= {tx_sreg[38:0], 1'b0};
                        end else begin
                            tx_crc <= {tx_crc[5:0], 1'b0};
                        end
                    end
                end
                WAIT_START: if (rise) begin
                    if (!cmd_in) begin
                        // Start bit is response bit 47; a zero leaves the CRC at zero.
                        rx_sreg <= 47'd0;
                        rx_cnt  <= 6'd1;
                        rx_crc  <= 7'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == TMO_LAST) tmo <= 1'b1;
                    end
                end
                RECV: if (rise) begin
                    rx_sreg <= {rx_sreg[45:0], cmd_in};
                    rx_cnt  <= rx_cnt + 6'd1;
                    if (rx_cnt < 6'd40) rx_crc <= crc7_next(rx_crc, cmd_in);
                    if (rx_cnt == 6'd47) begin
                        end_err  <= !cmd_in;
                        crc_err  <= !ctrl[7] && (rx_crc != rx_sreg[6:0]);
                        resp     <= rx_sreg[38:7];
                        resp_idx <= rx_sreg[44:39];
                    end
                end
                FINISH: begin
                    if (rise) fin_cnt <= fin_cnt + 4'd1;
                    if (fall && fin_cnt == 4'd8) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - scoreboard bench for sd_cmd_engine with a simple card model.
module tb_sd_cmd_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0, rw = 1'b0, sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, busy0, busy1, sdclk0, sdclk1;
    wire         cmd0, cmd1;
    logic        req0, req1;

    int tests = 0, fails = 0;

    logic [47:0] exp_frame_q[$];
    logic [31:0] exp_status_q[$];
    int          exp_rise_q[$];

    logic        card_en = 1'b0;
    logic [47:0] card_resp = 48'd0;
    int          card_start = 0;
    logic        card_drv, card_bit;

    int   rise_cnt = 0, fall_cnt = 0, cyc = 0, last_rise_cyc = 0, per_last = 0, rdy_errs = 0;
    logic prev_clk = 1'b0, req1_prev = 1'b0;
    logic hist [0:8191];

    pullup(cmd0);
    pullup(cmd1);

    assign req0 = bus_req && !sel;
    assign req1 = bus_req && sel;

    always_comb begin
        card_drv = 1'b0;
        card_bit = 1'b1;
        if (card_en && fall_cnt >= card_start && fall_cnt < card_start + 48) begin
            card_drv = 1'b1;
            card_bit = card_resp[47 - (fall_cnt - card_start)];
        end
    end
    assign cmd0 = (card_drv && !sel) ? card_bit : 1'bz;
    assign cmd1 = (card_drv && sel)  ? card_bit : 1'bz;

    sd_cmd_engine #(.CLKDIV(2), .TIMEOUT(64)) dut0 (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req0), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata0), .o_ready(ready0),
        .o_busy(busy0), .SD_CLK(sdclk0), .SD_CMD(cmd0));

    sd_cmd_engine #(.CLKDIV(1), .TIMEOUT(64)) dut1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req1), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata1), .o_ready(ready1),
        .o_busy(busy1), .SD_CLK(sdclk1), .SD_CMD(cmd1));

    always #5 clk = ~clk;

    // Monitor of the selected card bus: counts edges, records the line at each rising edge.
    always @(negedge clk) begin
        logic sc, ln;
        sc = sel ? sdclk1 : sdclk0;
        ln = sel ? cmd1 : cmd0;
        cyc++;
        if (sc && !prev_clk) begin
            rise_cnt++;
            hist[rise_cnt & 8191] = ln;
            per_last = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        if (!sc && prev_clk) fall_cnt++;
        prev_clk = sc;
        if (ready1 !== req1_prev) rdy_errs++;
        req1_prev = req1;
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_req = 1'b1; rw = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        bus_req = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus_req = 1'b1; rw = 1'b0; addr = a;
        @(posedge clk); #1;
        bus_req = 1'b0;
        d = sel ? rdata1 : rdata0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!(sel ? busy1 : busy0)) begin ok = 1'b1; break; end
        end
    endtask

    function automatic logic [47:0] frame_at(input int base);
        logic [47:0] f;
        f = 48'd0;
        for (int k = 1; k <= 48; k++) f = {f[46:0], hist[(base + k) & 8191]};
        return f;
    endfunction

    // Issue one command and check frame, edge count and STATUS against the scoreboard.
    task automatic run_cmd(input string name, input logic [31:0] a, input logic [7:0] c,
                           input bit answer, input logic [47:0] r);
        int base; bit ok; logic [31:0] st; logic [47:0] f; int nr;
        bus_write(2'd0, a);
        base = rise_cnt;
        card_resp  = r;
        card_start = fall_cnt + 50;
        card_en    = answer;
        bus_write(2'd1, {24'd0, c});
        wait_idle(ok);
        card_en = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL %s busy_stuck: busy never cleared", name); end
        f  = frame_at(base);
        nr = rise_cnt - base;
        tests++;
        if (f !== exp_frame_q[0]) begin
            fails++; $display("FAIL %s frame: got %h want %h", name, f, exp_frame_q[0]);
        end
        void'(exp_frame_q.pop_front());
        tests++;
        if (nr !== exp_rise_q[0]) begin
            fails++; $display("FAIL %s rises: got %0d want %0d", name, nr, exp_rise_q[0]);
        end
        void'(exp_rise_q.pop_front());
        bus_read(2'd2, st);
        tests++;
        if (st !== exp_status_q[0]) begin
            fails++; $display("FAIL %s status: got %h want %h", name, st, exp_status_q[0]);
        end
        void'(exp_status_q.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] v;
        tests++;
        if (busy0 !== 1'b0 || sdclk0 !== 1'b0 || ready0 !== 1'b0 || rdata0 !== 32'd0) begin
            fails++; $display("FAIL reset_outputs: busy=%b clk=%b ready=%b rdata=%h want 0", busy0, sdclk0, ready0, rdata0);
        end
        tests++;
        if (cmd0 !== 1'b1) begin fails++; $display("FAIL reset_cmd_released: line=%b want 1 (pulled up)", cmd0); end
        for (int i = 0; i < 4; i++) begin
            bus_read(i[1:0], v);
            tests++;
            if (v !== 32'd0) begin fails++; $display("FAIL reset_reg%0d: got %h want 0", i, v); end
        end
    endtask

    task automatic test_cmd0();
        exp_frame_q.push_back(48'h400000000095);
        exp_rise_q.push_back(56);
        exp_status_q.push_back(32'h0000_0002);
        run_cmd("cmd0", 32'd0, 8'h00, 1'b0, 48'd0);
    endtask

    task automatic test_cmd8(input string name, input logic [7:0] c, input logic [47:0] r,
                             input logic [31:0] st);
        logic [31:0] v;
        exp_frame_q.push_back(48'h48000001AA87);
        exp_rise_q.push_back(106);
        exp_status_q.push_back(st);
        run_cmd(name, 32'h0000_01AA, c, 1'b1, r);
        bus_read(2'd3, v);
        tests++;
        if (v !== 32'h0000_01AA) begin fails++; $display("FAIL %s resp: got %h want 000001aa", name, v); end
    endtask

    task automatic test_timeout();
        exp_frame_q.push_back(48'h48000001AA87);
        exp_rise_q.push_back(48 + 64 + 8);
        exp_status_q.push_back(32'h0000_0806);
        run_cmd("timeout", 32'h0000_01AA, 8'h48, 1'b0, 48'd0);
    endtask

    task automatic test_busy_writes_and_reset();
        int base; bit ok; logic [31:0] v; logic [47:0] f;
        bus_write(2'd0, 32'h0000_01AA);
        base = rise_cnt;
        bus_write(2'd1, 32'h0000_0008);
        repeat (10) @(posedge clk);
        bus_write(2'd0, 32'hDEAD_BEEF);
        bus_write(2'd1, 32'h0000_0005);
        wait_idle(ok);
        f = frame_at(base);
        tests++;
        if (!ok || f !== 48'h48000001AA87) begin
            fails++; $display("FAIL busy_write_frame: got %h ok=%0b want 48000001aa87", f, ok);
        end
        bus_read(2'd0, v);
        tests++;
        if (v !== 32'h0000_01AA) begin fails++; $display("FAIL busy_write_arg: got %h want 000001aa", v); end
        bus_read(2'd1, v);
        tests++;
        if (v !== 32'h0000_0008) begin fails++; $display("FAIL busy_write_ctrl: got %h want 00000008", v); end

        bus_write(2'd1, 32'h0000_0000);
        tests++;
        if (cmd0 !== 1'b0) begin fails++; $display("FAIL send_start_bit: line=%b want 0", cmd0); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (sdclk0 !== 1'b0 || cmd0 !== 1'b1 || busy0 !== 1'b0) begin
            fails++; $display("FAIL reset_mid_send: clk=%b line=%b busy=%b want 0/1/0", sdclk0, cmd0, busy0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        bus_read(2'd2, v);
        tests++;
        if (v !== 32'd0) begin fails++; $display("FAIL reset_mid_send_status: got %h want 0", v); end
    endtask

    task automatic test_clkdiv1();
        sel = 1'b1;
        repeat (2) @(posedge clk);
        test_cmd8("clkdiv1", 8'h48, 48'h08000001AA13, 32'h0000_0802);
        tests++;
        if (per_last !== 2) begin fails++; $display("FAIL clkdiv1_period: got %0d want 2", per_last); end
        tests++;
        if (rdy_errs !== 0) begin fails++; $display("FAIL ready_follow: %0d cycles off, want 0", rdy_errs); end
        sel = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_cmd0();
        test_cmd8("cmd8", 8'h48, 48'h08000001AA13, 32'h0000_0802);
        test_timeout();
        test_cmd8("crc_bad",  8'h48, 48'h08000001AA15, 32'h0000_080A);
        test_cmd8("crc_skip", 8'hC8, 48'h08000001AA15, 32'h0000_0802);
        test_cmd8("end_bad",  8'h48, 48'h08000001AA12, 32'h0000_0812);
        test_busy_writes_and_reset();
        test_clkdiv1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
